// File: rtl/sysarray_skew_feeder.sv
// Operand feed stage for a DIM x DIM systolic multiplier array; holds A and B, streams them diagonally skewed, then drains.
// Latency: start sampled at cycle c -> first beat at c+1, last beat at c+2*DIM-1, done pulse at c+2*DIM+DRAIN_CYCLES.
// No backpressure: writes and start are only honoured while idle. Optional SYSARRAY_FEED_LOOP_EN adds back-to-back passes.
module sysarray_skew_feeder #(
  parameter int n            = 31,
  parameter int DIM          = 5,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef SYSARRAY_FEED_LOOP_EN
  input  logic                 loop,
`endif
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [2:0]           wr_row,
  input  logic [2:0]           wr_col,
  input  logic [n:0]           wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 feed_valid,
  output logic                 done,
  output logic [DIM*(n+1)-1:0] a_out,
  output logic [DIM*(n+1)-1:0] b_out
);

  localparam int W  = n + 1;
  localparam int TW = 8;
  localparam logic [TW-1:0] T_LAST  = TW'(2 * DIM - 2);
  localparam logic [TW-1:0] DC_LAST = (DRAIN_CYCLES > 0) ? TW'(DRAIN_CYCLES - 1) : '0;
  localparam logic [3:0]    DIM_U   = 4'(DIM);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [TW-1:0]       drain_q, drain_d;
  logic [DIM*W-1:0]    a_q, a_d, b_q, b_d;
  logic                feed_q, feed_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [W-1:0]        a_mem [DIM][DIM];
  logic [W-1:0]        b_mem [DIM][DIM];
  logic                wr_ok;

  // busy_q also blocks the cycle right after DONE, so a write is never taken while busy is visible.
  assign wr_ok = wr_en && (state_q == S_IDLE) && !busy_q &&
                 ({1'b0, wr_row} < DIM_U) && ({1'b0, wr_col} < DIM_U);

  // Operand storage; cleared by reset only when looping is built in.
  always_ff @(posedge clock) begin
`ifdef SYSARRAY_FEED_LOOP_EN
    if (reset) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else
`endif
    if (wr_ok) begin
      if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
      else        a_mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          t_d     = '0;
        end
      end
      S_FEED: begin
        if (t_q == T_LAST) begin
          drain_d = '0;
          if (DRAIN_CYCLES == 0) state_d = S_DONE;
          else                   state_d = S_DRAIN;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DC_LAST) state_d = S_DONE;
        else                    drain_d = drain_q + 1'b1;
      end
      S_DONE: begin
`ifdef SYSARRAY_FEED_LOOP_EN
        if (loop) begin
          state_d = S_FEED;
          t_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat contents for step t: lane i carries element k where i+k == t, zero elsewhere.
  always_comb begin
    a_d    = '0;
    b_d    = '0;
    feed_d = (state_q == S_FEED);
    done_d = (state_q == S_DONE);
    busy_d = (state_q != S_IDLE);
    if (state_q == S_FEED) begin
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          if (t_q == TW'(i + k)) begin
            a_d[i*W +: W] = a_mem[i][k];
            b_d[i*W +: W] = b_mem[k][i];
          end
        end
      end
    end
  end

  // State and registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      feed_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      feed_q  <= feed_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign feed_valid = feed_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule
